// File: rtl/bio_gpio_filter.sv
// GPIO input conditioning for BIO: synchroniser, per-pin glitch filter, rise/fall event pulses.
// Optional sticky pending flags are built only when BIO_GPIO_FILTER_PEND_EN is defined.
module bio_gpio_filter #(
   parameter int NPINS       = 32,
   parameter int SYNC_STAGES = 2,   // legal 2..4
   parameter int CNT_W       = 4
) (
   input  logic             aclk,
   input  logic             resetn,
   input  logic [NPINS-1:0] pad_in,
   input  logic [NPINS-1:0] filt_en,
   input  logic [CNT_W-1:0] filt_thresh,
   output logic [NPINS-1:0] gpio_in,
   output logic [NPINS-1:0] rise_evt,
   output logic [NPINS-1:0] fall_evt,
   output logic [NPINS-1:0] evt_pend,
   input  logic [NPINS-1:0] evt_clr
);

   logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q;
   logic [NPINS-1:0]                  sync;
   logic [NPINS-1:0]                  stable_q, stable_next;
   logic [NPINS-1:0][CNT_W-1:0]       cnt_q, cnt_next;
   logic [NPINS-1:0]                  rise_q, fall_q;

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // NOTE: every output of this block is given a default first so no latch is inferred.
   always_comb begin
      stable_next = stable_q;
      cnt_next    = '0;
      for (int i = 0; i < NPINS; i++) begin
         if (!filt_en[i]) begin
            stable_next[i] = sync[i];
         end else if (sync[i] != stable_q[i]) begin
            // >= lets a lowered threshold take effect immediately and keeps cnt from wrapping.
            if (cnt_q[i] >= filt_thresh) begin
               stable_next[i] = sync[i];
            end else begin
               cnt_next[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         stable_q <= '0;
         cnt_q    <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
      end else begin
         stable_q <= stable_next;
         cnt_q    <= cnt_next;
         rise_q   <= stable_next & ~stable_q;
         fall_q   <= ~stable_next & stable_q;
      end
   end

   assign gpio_in  = stable_q;
   assign rise_evt = rise_q;
   assign fall_evt = fall_q;

`ifdef BIO_GPIO_FILTER_PEND_EN
   logic [NPINS-1:0] pend_q;

   // A new edge in the same cycle as a clear keeps the flag set.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         pend_q <= '0;
      end else begin
         pend_q <= (pend_q & ~evt_clr) | rise_q | fall_q;
      end
   end

   assign evt_pend = pend_q;
`else
   assign evt_pend = '0;
   wire unused_evt_clr = &{1'b0, evt_clr};
`endif

endmodule
